// File: rtl/tcm_pkg.sv
// Shared types and constants for the TCM arbiter: request bundle, read-return
// owner encoding and the default SRAM geometry.
package tcm_pkg;

  localparam int TCM_WORD_BYTES    = 4;
  localparam int TCM_DEFAULT_DEPTH = 256;

  typedef enum logic {OWN_P0, OWN_P1} tcm_owner_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } tcm_req_t;

  // Byte address to SRAM word index.
  function automatic logic [31:0] word_idx(input logic [31:0] addr);
    return addr >> $clog2(TCM_WORD_BYTES);
  endfunction

endpackage

// File: rtl/tcm_arbiter.sv
// Two-port arbiter for the single-port TCM SRAM: core (port 0) has fixed
// priority, port 1 is guaranteed a grant after MAX_WAIT contested losses.
module tcm_arbiter
  import tcm_pkg::*;
#(
  parameter int DEPTH    = TCM_DEFAULT_DEPTH,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [3:0]  p0_be,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [3:0]  p1_be,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic        sram_cen,
  output logic        sram_wen,
  output logic [3:0]  sram_ben,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_din,
  input  logic [31:0] sram_dout
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  logic [CW-1:0] wait_cnt;
  logic          rd_pend;
  tcm_owner_e    rd_owner;
  logic          rd_err;
  logic          wr_err_pend;
  tcm_owner_e    wr_err_owner;

  tcm_req_t   p0_r, p1_r, sel_r;
  tcm_owner_e gnt_owner;
  logic       gnt_any;
  logic       out_of_range;
  logic       access;

  assign p0_r = '{we: p0_we, be: p0_be, addr: p0_addr, wdata: p0_wdata};
  assign p1_r = '{we: p1_we, be: p1_be, addr: p1_addr, wdata: p1_wdata};

  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!rst) begin
      if (p0_req && p1_req) begin
        if (wait_cnt == WAIT_MAX) p1_gnt = 1'b1;
        else                      p0_gnt = 1'b1;
      end else if (p0_req) begin
        p0_gnt = 1'b1;
      end else if (p1_req) begin
        p1_gnt = 1'b1;
      end
    end
  end

  assign gnt_any      = p0_gnt | p1_gnt;
  assign gnt_owner    = p1_gnt ? OWN_P1 : OWN_P0;
  assign sel_r        = p1_gnt ? p1_r : p0_r;
  assign out_of_range = word_idx(sel_r.addr) >= 32'(DEPTH);
  assign access       = gnt_any && !out_of_range;

  // Out-of-range accesses are still granted but never touch the macro.
  always_comb begin
    sram_cen  = 1'b1;
    sram_wen  = 1'b1;
    sram_ben  = 4'hF;
    sram_addr = '0;
    sram_din  = '0;
    if (access) begin
      sram_cen  = 1'b0;
      sram_wen  = ~sel_r.we;
      sram_ben  = ~sel_r.be;
      sram_addr = word_idx(sel_r.addr);
      sram_din  = sel_r.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt     <= '0;
      rd_pend      <= 1'b0;
      rd_owner     <= OWN_P0;
      rd_err       <= 1'b0;
      wr_err_pend  <= 1'b0;
      wr_err_owner <= OWN_P0;
    end else begin
      if (!p1_req || p1_gnt)     wait_cnt <= '0;
      else if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;

      rd_pend     <= gnt_any && !sel_r.we;
      wr_err_pend <= gnt_any && sel_r.we && out_of_range;
      if (gnt_any) begin
        rd_owner     <= gnt_owner;
        rd_err       <= out_of_range;
        wr_err_owner <= gnt_owner;
      end
    end
  end

  // Returns are masked while rst is high so a read in flight is dropped.
  always_comb begin
    p0_rvalid = !rst && rd_pend && (rd_owner == OWN_P0);
    p1_rvalid = !rst && rd_pend && (rd_owner == OWN_P1);
    p0_rdata  = (p0_rvalid && !rd_err) ? sram_dout : '0;
    p1_rdata  = (p1_rvalid && !rd_err) ? sram_dout : '0;
    p0_err    = (p0_rvalid && rd_err) ||
                (!rst && wr_err_pend && (wr_err_owner == OWN_P0));
    p1_err    = (p1_rvalid && rd_err) ||
                (!rst && wr_err_pend && (wr_err_owner == OWN_P1));
  end

endmodule
